// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit.
// Contents:
//   DEF_DATA_W  - default data/address width
//   REG_ADDR_W  - register-file address width
//   mem_state_e - access FSM states (IDLE, BUSY, RESP)
package mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Clear/enable counter that flags the last allowed BUSY cycle.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   i_clr      - synchronous clear (wins over i_en)
//   i_en       - count enable
//   o_tc       - high while the count equals TIMEOUT-1
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The owner stops enabling at terminal count, so the counter never wraps.
    assign o_tc = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: consumes EX/MEM outputs, performs loads/stores over
// a req/ack data-memory handshake, stalls the front end while an access is
// outstanding, and presents registered write-back results.
// Optional feature macro: MEM_ALIGN_CHECK_EN (reject non-word-aligned accesses).
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   ex_addr/ex_wdata    - ALU result (address) and store data
//   ex_rd               - destination register
//   ex_mem_wen/ex_wb_sel- store request / load (write back memory data)
//   dmem_req/we/addr/wdata, dmem_ack, dmem_rdata - data memory handshake
//   stall               - hold for IF/ID/EX
//   wb_data/wb_rd/wb_wen- write-back result toward MEM/WB
//   err                 - sticky timeout/misalignment flag
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     ex_addr,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_wen,
    input  logic                  ex_wb_sel,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  stall,
    output logic [DATA_W-1:0]     wb_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_wen,
    output logic                  err
);

    mem_state_e              r_state;
    mem_state_e              w_state_nxt;
    logic                    r_dmem_req;
    logic                    r_dmem_we;
    logic [DATA_W-1:0]       r_dmem_addr;
    logic [DATA_W-1:0]       r_dmem_wdata;
    logic [DATA_W-1:0]       r_wb_data;
    logic [REG_ADDR_W-1:0]   r_wb_rd;
    logic                    r_wb_wen;
    logic                    r_err;
    logic                    w_access;
    logic                    w_misalign;
    logic                    w_tc;

    assign w_access = ex_mem_wen | ex_wb_sel;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (ex_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .reset (reset),
        .i_clr (r_state == IDLE),
        .i_en  ((r_state == BUSY) && !dmem_ack && !w_tc),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_access) w_state_nxt = w_misalign ? RESP : BUSY;
            BUSY:    if (dmem_ack || w_tc) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_wb_data    <= '0;
            r_wb_rd      <= '0;
            r_wb_wen     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_access) begin
                        r_wb_data <= ex_addr;
                        r_wb_rd   <= ex_rd;
                        r_wb_wen  <= (ex_rd != '0);
                    end else if (w_misalign) begin
                        r_err    <= 1'b1;
                        r_wb_wen <= 1'b0;
                    end else begin
                        // A store wins when both store and load are flagged.
                        r_dmem_addr  <= ex_addr;
                        r_dmem_wdata <= ex_wdata;
                        r_dmem_we    <= ex_mem_wen;
                        r_dmem_req   <= 1'b1;
                        r_wb_rd      <= ex_rd;
                        r_wb_wen     <= 1'b0;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        if (!r_dmem_we) begin
                            r_wb_data <= dmem_rdata;
                            r_wb_wen  <= (r_wb_rd != '0);
                        end else begin
                            r_wb_wen  <= 1'b0;
                        end
                    end else if (w_tc) begin
                        r_dmem_req <= 1'b0;
                        r_err      <= 1'b1;
                        r_wb_wen   <= 1'b0;
                    end
                end
                default: begin
                    r_wb_wen <= 1'b0;
                end
            endcase
        end
    end

    // RESP deliberately releases the stall: the ex_* inputs still hold the
    // consumed instruction and must be allowed to advance.
    assign stall      = ((r_state == IDLE) && w_access) || (r_state == BUSY);
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign wb_data    = r_wb_data;
    assign wb_rd      = r_wb_rd;
    assign wb_wen     = r_wb_wen;
    assign err        = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] ex_addr, ex_wdata;
    logic [4:0]    ex_rd;
    logic          ex_mem_wen, ex_wb_sel;
    logic          dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    logic          stall;
    logic [DW-1:0] wb_data;
    logic [4:0]    wb_rd;
    logic          wb_wen;
    logic          err;

    mem_access_unit #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .ex_mem_wen(ex_mem_wen), .ex_wb_sel(ex_wb_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .wb_data(wb_data), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level reference state: what the MEM/WB boundary should show.
    logic [DW-1:0] m_wb_data;
    logic [4:0]    m_wb_rd;
    logic          m_err;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one instruction from IDLE and follow it until the unit is back in
    // IDLE. dly = number of BUSY cycles before ack (dly >= TO means never ack).
    task automatic do_instr(input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [4:0] rd, input logic wen, input logic sel,
                            input int dly, input logic [DW-1:0] rdata);
        logic acc;
        logic tmo;
        logic exp_wen;
        acc = wen | sel;
        tmo = (dly >= TO);
        ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
        ex_mem_wen = wen; ex_wb_sel = sel;
        dmem_ack = acc ? 1'b0 : 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #1;
        chk("stall_issue", stall, acc);
        if (!acc) begin
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            m_wb_data = addr;
            m_wb_rd   = rd;
            chk("alu_wb_data", wb_data, m_wb_data);
            chk("alu_wb_rd", wb_rd, m_wb_rd);
            chk("alu_wb_wen", wb_wen, rd != 0);
            chk("alu_req", dmem_req, 0);
            chk("alu_err", err, m_err);
            return;
        end
`ifdef MEM_ALIGN_CHECK_EN
        if (addr[1:0] != 2'b00) begin
            @(posedge clk); #1;
            m_err = 1'b1;
            chk("mis_req", dmem_req, 0);
            chk("mis_stall", stall, 0);
            chk("mis_err", err, 1);
            chk("mis_wb_wen", wb_wen, 0);
            @(posedge clk); #1;
            chk("mis_idle_req", dmem_req, 0);
            chk("mis_idle_wen", wb_wen, 0);
            return;
        end
`endif
        for (int k = 0; k < TO; k++) begin
            @(posedge clk); #1;
            chk("busy_req", dmem_req, 1);
            chk("busy_addr", dmem_addr, addr);
            chk("busy_we", dmem_we, wen);
            chk("busy_wdata", dmem_wdata, wdata);
            chk("busy_stall", stall, 1);
            chk("busy_wb_wen", wb_wen, 0);
            if (k == dly) begin
                dmem_ack = 1'b1;
                dmem_rdata = rdata;
                break;
            end
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        m_wb_rd = rd;
        if (tmo) m_err = 1'b1;
        else if (!wen) m_wb_data = rdata;
        exp_wen = !tmo && !wen && (rd != 0);
        chk("resp_req", dmem_req, 0);
        chk("resp_stall", stall, 0);
        chk("resp_wb_wen", wb_wen, exp_wen);
        chk("resp_wb_data", wb_data, m_wb_data);
        chk("resp_wb_rd", wb_rd, m_wb_rd);
        chk("resp_err", err, m_err);
        @(posedge clk); #1;
        chk("post_req", dmem_req, 0);
        chk("post_wb_wen", wb_wen, 0);
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [4:0]    rrd;
        int            kind;
        int            d;

        reset = 1'b1;
        ex_addr = '0; ex_wdata = '0; ex_rd = '0;
        ex_mem_wen = 1'b0; ex_wb_sel = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        m_wb_data = '0; m_wb_rd = '0; m_err = 1'b0;
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_wen", wb_wen, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Directed cases
        do_instr(32'h0000_0123, 32'h0, 5'd5, 1'b0, 1'b0, 0, 32'h0);
        do_instr(32'h0000_0040, 32'h0, 5'd7, 1'b0, 1'b1, 2, 32'hDEAD_BEEF);
        do_instr(32'h0000_0080, 32'h0000_55AA, 5'd9, 1'b1, 1'b1, 1, 32'h0);
        do_instr(32'h0000_0100, 32'h0, 5'd3, 1'b0, 1'b1, TO, 32'h0);
        do_instr(32'h0000_0456, 32'h0, 5'd4, 1'b0, 1'b0, 0, 32'h0);
        do_instr(32'h0000_0042, 32'h0, 5'd6, 1'b0, 1'b1, 0, 32'h1234_5678);

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            ra   = $urandom;
            ra[1:0] = 2'b00;
            rrd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            kind = $urandom_range(0, 9);
            d    = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 5);
            if (kind < 4)
                do_instr(ra, $urandom, rrd, 1'b0, 1'b0, d, $urandom);
            else if (kind < 7)
                do_instr(ra, $urandom, rrd, 1'b0, 1'b1, d, $urandom);
            else
                do_instr(ra, $urandom, rrd, 1'b1, 1'($urandom_range(0, 1)), d, $urandom);
        end

        // Reset in the middle of an outstanding load
        ex_addr = 32'h0000_0200; ex_rd = 5'd8; ex_mem_wen = 1'b0; ex_wb_sel = 1'b1;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_req", dmem_req, 1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_req", dmem_req, 0);
        chk("mid_rst_err", err, 0);
        m_err = 1'b0; m_wb_data = '0; m_wb_rd = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        do_instr(32'h0000_0777, 32'h0, 5'd0, 1'b0, 1'b0, 0, 32'h0);
        chk("after_rst_req", dmem_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs: address/ALU result, store data, destination register, memory write enable, write-back select.
- Performs loads/stores to data memory over a req/ack handshake and stalls the front of the pipeline while an access is outstanding.
- Presents registered write-back results (data, rd, write enable) toward the MEM/WB boundary.

Parameters:
- DATA_W, 32, data and address width.
- TIMEOUT, 16, maximum BUSY cycles without dmem_ack before the access is aborted (minimum 2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_addr  in  DATA_W  EX/MEM data_1: ALU result / memory address.
- ex_wdata  in  DATA_W  EX/MEM data_2: store data.
- ex_rd  in  5  destination register.
- ex_mem_wen  in  1  store request.
- ex_wb_sel  in  1  1 = load (write back memory data), 0 = write back ex_addr.
- dmem_req  out  1  memory request, held until acknowledged.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DATA_W  memory address.
- dmem_wdata  out  DATA_W  store data.
- dmem_ack  in  1  memory completion; load data is valid in the same cycle.
- dmem_rdata  in  DATA_W  load data.
- stall  out  1  pipeline hold to IF/ID/EX (EX/MEM inputs held stable).
- wb_data  out  DATA_W  write-back value.
- wb_rd  out  5  write-back register.
- wb_wen  out  1  register-file write enable, one-cycle pulse per instruction.
- err  out  1  sticky access error (timeout/misalign).

Behaviour:
- Reset (async, immediate): state=IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_data, wb_rd, wb_wen, err, and the timeout count all 0. stall follows its combinational definition from IDLE.
- Access detection: access = ex_mem_wen | ex_wb_sel. If both are set, the instruction is a store (ex_mem_wen wins) and wb_wen=0.
- stall: combinational. stall = (IDLE & access) | BUSY. stall=0 in RESP.
- States:
  - IDLE, no access: at the edge, wb_data<=ex_addr, wb_rd<=ex_rd, wb_wen<=(ex_rd!=0). Latency is 1 cycle. Stay in IDLE.
  - IDLE, access: at the edge, latch dmem_addr<=ex_addr, dmem_wdata<=ex_wdata, dmem_we<=ex_mem_wen, wb_rd<=ex_rd; dmem_req<=1; wb_wen<=0; count<=0; go to BUSY.
  - BUSY: dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until dmem_ack is sampled high.
    - On ack: dmem_req<=0. For a load, wb_data<=dmem_rdata and wb_wen<=(wb_rd!=0). For a store, wb_wen<=0. Go to RESP.
    - No ack with count==TIMEOUT-1: dmem_req<=0, err<=1, wb_wen<=0, go to RESP.
    - Otherwise count<=count+1.
  - RESP: one cycle with stall=0, so upstream advances. The held instruction still present on the ex_* inputs is ignored (already consumed). At the edge, wb_wen<=0 and go to IDLE.
- Minimum load latency: request is visible 1 cycle after the instruction arrives. With ack in the first BUSY cycle, wb outputs are valid in the following cycle (RESP). Total stall is 2 cycles.
- dmem_ack outside BUSY is ignored.
- err is sticky and is cleared only by reset.
- Reset mid-BUSY drops dmem_req immediately. No retry after reset.
- count width is clog2(TIMEOUT). No wrap-around is possible because the counter exits at TIMEOUT-1.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined: an access from IDLE with ex_addr[1:0]!=0 issues no request (dmem_req stays 0). It sets err<=1 and wb_wen<=0, then goes directly to RESP (stall=1 for 1 cycle).
- MEM_ALIGN_CHECK_EN undefined: the address passes to dmem_addr unmodified; no alignment error exists.

Decomposition:
- Shared package mem_pkg: state enum (IDLE, BUSY, RESP), DATA_W default, REG_ADDR_W=5.
- One natural sub-module: mem_timeout_ctr, a clear/enable counter with a terminal-count output at TIMEOUT-1.

Test Plan:
- ALU op: ex_addr=0x0000_0123, ex_rd=5, ex_wb_sel=0, ex_mem_wen=0 -> stall=0; next cycle wb_data=0x123, wb_rd=5, wb_wen=1.
- Load with 3-cycle-late ack, dmem_rdata=0xDEADBEEF, ex_rd=7, ex_addr=0x40 -> dmem_req=1 with dmem_addr=0x40 and dmem_we=0 held 3 cycles; then RESP with wb_data=0xDEADBEEF, wb_rd=7, wb_wen=1, stall=0; no second request.
- Store ex_addr=0x80, ex_wdata=0x55AA, with ex_wb_sel=1 also set -> dmem_we=1, dmem_wdata=0x55AA; ack after 1 cycle; wb_wen=0 throughout.
- Load, no ack, TIMEOUT=16 -> dmem_req high exactly 16 cycles, then err=1 and wb_wen=0; a following ALU op writes back normally while err stays 1.
- reset asserted mid-BUSY -> dmem_req=0 and err=0 immediately; after release an ALU op with ex_rd=0 gives wb_wen=0.
- MEM_ALIGN_CHECK_EN defined, load ex_addr=0x42 -> dmem_req never asserted, stall=1 for one cycle, err=1.
